sin_datapath: RTL and testbench
===============================

// Module: sin_datapath
// PURPOSE
//  Datapath half of the iterative Taylor-series sine unit; paired with sin_controller, which drives every control input here.
//  Computes sin(x) = x - x^3/3! + x^5/5! - ... over N_TERMS terms in signed fixed point.
//  Returns co (last term reached) to the controller; result is valid while the controller reports done.
// PARAMETERS
//  WIDTH    16  signed data width for x, x^2, term and result
//  FRAC     14  fractional bits (default Q2.14, valid x range [-pi/2, pi/2])
//  N_TERMS  4   series terms incl. x (4 -> x, x^3, x^5, x^7); legal range 2..8
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  x               in   WIDTH  signed angle; sampled only in the cycle init_mult_reg/load_xpowertwo are high
//  init_xpowertwo  in   1      clear x2_reg
//  load_xpowertwo  in   1      x2_reg <= fxmul(x, x)
//  init_mult_reg   in   1      term_reg <= x
//  load_mult_reg   in   1      term_reg <= fxmul(term_reg, sel_mult_in ? x2_reg : coef(cnt))
//  sel_mult_in     in   1      multiplier B-operand select (1: x2_reg, 0: coefficient ROM)
//  init_result     in   1      result_reg <= x
//  load_result     in   1      result_reg <= sat(result_reg -/+ term_reg)
//  init_counter    in   1      cnt <= 0
//  inc_counter     in   1      cnt <= cnt + 1
//  result          out  WIDTH  result_reg
//  co              out  1      combinational: cnt == N_TERMS-1
// BEHAVIOUR
//  - Async reset: x2_reg, term_reg, result_reg, cnt = 0; result = 0, co = 0.
//  - Registers update on clk rising edge; each has own init/load pair; init has priority over load; neither -> hold.
//  - cnt width CNT_W = $clog2(N_TERMS); init_counter beats inc_counter; inc at N_TERMS-1 holds (no wrap).
//  - fxmul(a,b): full 2*WIDTH signed product, arithmetic shift right FRAC, saturate to WIDTH signed range.
//  - coef(k) = round(2^FRAC / ((2k)(2k+1))), k = 1..N_TERMS-1 (k=1: 2731, k=2: 819, k=3: 390 at FRAC=14);
//    coef(0) = 0; ROM is a localparam function of FRAC, no memory.
//  - load_result: cnt odd -> subtract term, cnt even -> add term; saturate to WIDTH signed range.
//  - Iteration contract (per controller): init cycle: x2<=x*x, term<=x, result<=x, cnt 0->1;
//    then per term k: mult1 term*=x2, mult2 term*=coef(k), add_sub result-/+=term, cnt++;
//    co high during add_sub of k = N_TERMS-1 -> controller returns to idle.
//  - Latency: 1 + 3*(N_TERMS-1) cycles after controller leaves starting (10 at default).
//  - Simultaneous load_mult_reg and load_result: result uses OLD term_reg (pre-update value).
//  - Reset mid-iteration: all regs clear immediately; result 0; next run must start from init.
//  - x changing outside init cycle has no effect on result.
// CONFIGURATION
//  SIN_DP_ROUND_EN defined: fxmul adds 2^(FRAC-1) to the product before shift (round half up);
//    improves accuracy, adds 1 adder on mult path.
//  Not defined: truncation (round toward -inf); test tolerances below hold for both.
// TESTING
//  T1 x=0, full sequence -> result=0, co high only in last add_sub, cnt stops at 3.
//  T2 x=8192 (0.5) -> result 7855 +/-4 LSB; after mult2 k=1 term = -? no: term = 341 +/-2 (x^3/6).
//  T3 x=25736 (pi/2) -> result 16384 +/-12 LSB; no saturation flagged in intermediate term.
//  T4 x=-8192 -> result -7855 +/-4 LSB (odd symmetry with T2 within 1 LSB).
//  T5 init_result=load_result=1 same edge -> result_reg = x; init_counter=inc_counter=1 -> cnt=0.
//  T6 rst_n low during mult2 of k=2 -> result=0, co=0 asynchronously; rerun of T2 after release -> 7855 +/-4.

Source files
------------

// File: rtl/sin_datapath.sv
// sin_datapath: datapath half of the iterative Taylor-series sine unit.
// Evaluates sin(x) = x - x^3/3! + x^5/5! - ... in signed Qm.FRAC fixed point,
// one register update per control pulse from the paired sin_controller.
// Optional feature macro: SIN_DP_ROUND_EN
//   defined   -> fxmul rounds half up (adds 2^(FRAC-1) before the shift)
//   undefined -> fxmul truncates (round toward -inf)
module sin_datapath #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int N_TERMS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x,
  input  logic                    init_xpowertwo,
  input  logic                    load_xpowertwo,
  input  logic                    init_mult_reg,
  input  logic                    load_mult_reg,
  input  logic                    sel_mult_in,
  input  logic                    init_result,
  input  logic                    load_result,
  input  logic                    init_counter,
  input  logic                    inc_counter,
  output logic signed [WIDTH-1:0] result,
  output logic                    co
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic signed [WIDTH-1:0] MAX_S   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_S   = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SIN_DP_ROUND_EN
  localparam logic signed [PW-1:0]    RND_C   = {{(PW-1){1'b0}}, 1'b1} <<< (FRAC - 1);
`endif

  // Clamp a full-width product back into the WIDTH signed range.
  function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
    logic signed [WIDTH-1:0] r;
    if ((v[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b0}}) ||
        (v[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b1}})) begin
      r = v[WIDTH-1:0];
    end else if (v[PW-1]) begin
      r = MIN_S;
    end else begin
      r = MAX_S;
    end
    return r;
  endfunction

  // Clamp a one-bit-extended sum/difference into the WIDTH signed range.
  function automatic logic signed [WIDTH-1:0] sat_acc(input logic [WIDTH:0] v);
    logic signed [WIDTH-1:0] r;
    if (v[WIDTH] == v[WIDTH-1]) begin
      r = v[WIDTH-1:0];
    end else if (v[WIDTH]) begin
      r = MIN_S;
    end else begin
      r = MAX_S;
    end
    return r;
  endfunction

  // Fixed-point multiply: full signed product, optional rounding, >>> FRAC, saturate.
  function automatic logic signed [WIDTH-1:0] fxmul(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pb;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    pa = {{(PW-WIDTH){a[WIDTH-1]}}, a};
    pb = {{(PW-WIDTH){b[WIDTH-1]}}, b};
    p  = pa * pb;
`ifdef SIN_DP_ROUND_EN
    p  = p + RND_C;
`endif
    s  = p >>> FRAC;
    return sat_prod(s);
  endfunction

  // Series coefficient 1/((2k)(2k+1)) in Q.FRAC, rounded to nearest.
  function automatic logic signed [WIDTH-1:0] coef_calc(input int k);
    int d;
    int q;
    d = (32'sd2 * k) * (32'sd2 * k + 32'sd1);
    q = ((32'sd1 <<< FRAC) + d / 32'sd2) / d;
    return q[WIDTH-1:0];
  endfunction

  // Packs coef(0..N_TERMS-1) into one constant vector; coef(0) is zero.
  function automatic logic [N_TERMS*WIDTH-1:0] build_rom();
    logic [N_TERMS*WIDTH-1:0] rom;
    rom = {(N_TERMS*WIDTH){1'b0}};
    for (int k = 1; k < N_TERMS; k++) begin
      rom[k*WIDTH +: WIDTH] = coef_calc(k);
    end
    return rom;
  endfunction

  localparam logic [N_TERMS*WIDTH-1:0] COEF_ROM = build_rom();

  logic signed [WIDTH-1:0] r_x2;
  logic signed [WIDTH-1:0] r_term;
  logic signed [WIDTH-1:0] r_result;
  logic [CNT_W-1:0]        r_cnt;

  logic signed [WIDTH-1:0] w_coef;
  logic signed [WIDTH-1:0] w_mul_b;
  logic signed [WIDTH-1:0] w_x2_next;
  logic signed [WIDTH-1:0] w_term_next;
  logic [WIDTH:0]          w_acc_wide;
  logic signed [WIDTH-1:0] w_result_next;

  // Coefficient ROM lookup indexed by the term counter.
  always_comb begin
    w_coef = {WIDTH{1'b0}};
    for (int k = 1; k < N_TERMS; k++) begin
      w_coef = (r_cnt == CNT_W'(k)) ? COEF_ROM[k*WIDTH +: WIDTH] : w_coef;
    end
  end

  // Multiplier operand select, products, and alternating-sign accumulate.
  always_comb begin
    w_x2_next   = fxmul(x, x);
    w_mul_b     = sel_mult_in ? r_x2 : w_coef;
    w_term_next = fxmul(r_term, w_mul_b);
    // Odd counter values are the negative series terms (x^3, x^7, ...).
    if (r_cnt[0]) begin
      w_acc_wide = {r_result[WIDTH-1], r_result} - {r_term[WIDTH-1], r_term};
    end else begin
      w_acc_wide = {r_result[WIDTH-1], r_result} + {r_term[WIDTH-1], r_term};
    end
    w_result_next = sat_acc(w_acc_wide);
  end

  // x^2 register: cleared by init, loaded with x*x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x2 <= {WIDTH{1'b0}};
    end else if (init_xpowertwo) begin
      r_x2 <= {WIDTH{1'b0}};
    end else if (load_xpowertwo) begin
      r_x2 <= w_x2_next;
    end
  end

  // Current series term: seeded with x, then multiplied by x^2 and the coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term <= {WIDTH{1'b0}};
    end else if (init_mult_reg) begin
      r_term <= x;
    end else if (load_mult_reg) begin
      r_term <= w_term_next;
    end
  end

  // Running sum: seeded with x; accumulate reads the pre-update term value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {WIDTH{1'b0}};
    end else if (init_result) begin
      r_result <= x;
    end else if (load_result) begin
      r_result <= w_result_next;
    end
  end

  // Term counter: clear wins over increment, saturates at the last term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (init_counter) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc_counter && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign result = r_result;
  assign co     = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_sin_datapath.sv
// tb_sin_datapath: directed self-checking bench for sin_datapath
// (default build, truncating fxmul, Q2.14, 4 terms).
module tb_sin_datapath;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] x;
  logic               init_xpowertwo;
  logic               load_xpowertwo;
  logic               init_mult_reg;
  logic               load_mult_reg;
  logic               sel_mult_in;
  logic               init_result;
  logic               load_result;
  logic               init_counter;
  logic               inc_counter;
  logic signed [15:0] result;
  logic               co;

  int n_total;
  int n_bad;

  sin_datapath #(
    .WIDTH   (16),
    .FRAC    (14),
    .N_TERMS (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .init_xpowertwo (init_xpowertwo),
    .load_xpowertwo (load_xpowertwo),
    .init_mult_reg  (init_mult_reg),
    .load_mult_reg  (load_mult_reg),
    .sel_mult_in    (sel_mult_in),
    .init_result    (init_result),
    .load_result    (load_result),
    .init_counter   (init_counter),
    .inc_counter    (inc_counter),
    .result         (result),
    .co             (co)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_ctl();
    init_xpowertwo = 1'b0;
    load_xpowertwo = 1'b0;
    init_mult_reg  = 1'b0;
    load_mult_reg  = 1'b0;
    sel_mult_in    = 1'b0;
    init_result    = 1'b0;
    load_result    = 1'b0;
    init_counter   = 1'b0;
    inc_counter    = 1'b0;
  endtask

  // Apply current controls on the next edge, then park x on junk.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr_ctl();
    x = 16'sh5A5A;
  endtask

  // Controller "starting" cycle then the init cycle (cnt 0 -> 1).
  task automatic do_start(input logic signed [15:0] xv);
    init_counter   = 1'b1;
    init_xpowertwo = 1'b1;
    cyc();
    x              = xv;
    load_xpowertwo = 1'b1;
    init_mult_reg  = 1'b1;
    init_result    = 1'b1;
    inc_counter    = 1'b1;
    cyc();
  endtask

  task automatic do_mult(input logic use_x2);
    load_mult_reg = 1'b1;
    sel_mult_in   = use_x2;
    cyc();
  endtask

  task automatic do_addsub(input logic exp_co, input string tag);
    check_val({tag, "_co"}, 32'(co), 32'(exp_co));
    load_result = 1'b1;
    inc_counter = 1'b1;
    cyc();
  endtask

  task automatic run_full(input logic signed [15:0] xv, input string tag,
                          input logic signed [15:0] exp_res);
    do_start(xv);
    for (int k = 1; k < 4; k++) begin
      do_mult(1'b1);
      do_mult(1'b0);
      do_addsub(k == 3, tag);
    end
    check_val({tag, "_res"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    x       = 16'sd0;
    clr_ctl();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_result", 32'(result), 32'sd0);
    check_val("rst_co", 32'(co), 32'sd0);
    rst_n = 1'b1;
    cyc();

    // T1: x = 0
    run_full(16'sd0, "t1", 16'sd0);
    check_val("t1_co_end", 32'(co), 32'sd1);
    inc_counter = 1'b1;
    cyc();
    check_val("t1_co_nowrap", 32'(co), 32'sd1);

    // T2: x = 0.5 -> 8192 - 341 + 4 - 0
    run_full(16'sd8192, "t2", 16'sd7855);

    // x = 1.0 -> 16384 - 2731 + 136 - 3
    run_full(16'sd16384, "x1", 16'sd13786);

    // T4: x = -0.5, floor rounding: -8192 + 342 - 5 + 1
    run_full(-16'sd8192, "t4", -16'sd7854);

    // Intermediate term after mult2 of k=1 for x = 0.5 (x^3/6)
    do_start(16'sd8192);
    do_mult(1'b1);
    do_mult(1'b0);
    x = 16'sd0; init_result = 1'b1; init_counter = 1'b1;
    cyc();
    load_result = 1'b1;
    cyc();
    check_val("t2_term", 32'(result), 32'sd341);

    // Simultaneous multiply and accumulate uses the old term
    do_start(16'sd8192);
    load_mult_reg = 1'b1; sel_mult_in = 1'b1; load_result = 1'b1;
    cyc();
    check_val("old_term", 32'(result), 32'sd0);
    load_result = 1'b1;
    cyc();
    check_val("new_term", 32'(result), -32'sd2048);

    // T5: init beats load on result, init beats inc on counter
    do_start(16'sd8192);
    x = 16'sd1234; init_result = 1'b1; load_result = 1'b1;
    cyc();
    check_val("t5_init_prio", 32'(result), 32'sd1234);
    inc_counter = 1'b1;
    cyc();
    init_counter = 1'b1; inc_counter = 1'b1;
    cyc();
    check_val("t5_cnt_clr", 32'(co), 32'sd0);
    for (int i = 0; i < 3; i++) begin
      inc_counter = 1'b1;
      cyc();
    end
    check_val("t5_cnt_top", 32'(co), 32'sd1);

    // Accumulator saturation: positive add
    x = 16'sd32767; init_mult_reg = 1'b1; init_result = 1'b1; init_counter = 1'b1;
    cyc();
    load_result = 1'b1;
    cyc();
    check_val("sat_add_pos", 32'(result), 32'sd32767);

    // Accumulator saturation: negative subtract (odd cnt)
    x = -16'sd32768; init_result = 1'b1; init_counter = 1'b1;
    cyc();
    x = 16'sd32767; init_mult_reg = 1'b1; inc_counter = 1'b1;
    cyc();
    load_result = 1'b1;
    cyc();
    check_val("sat_sub_neg", 32'(result), -32'sd32768);

    // fxmul saturation: x^2 of -2.0 and term overflow
    x = -16'sd32768; load_xpowertwo = 1'b1;
    cyc();
    x = 16'sd16384; init_mult_reg = 1'b1;
    cyc();
    do_mult(1'b1);
    do_mult(1'b1);
    x = 16'sd0; init_result = 1'b1; init_counter = 1'b1;
    cyc();
    load_result = 1'b1;
    cyc();
    check_val("sat_mul", 32'(result), 32'sd32767);

    // T6: reset during mult2 of k=2, then rerun T2
    do_start(16'sd8192);
    do_mult(1'b1);
    do_mult(1'b0);
    do_addsub(1'b0, "t6");
    do_mult(1'b1);
    load_mult_reg = 1'b1; sel_mult_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_res", 32'(result), 32'sd0);
    check_val("t6_async_co", 32'(co), 32'sd0);
    @(posedge clk);
    #1;
    check_val("t6_held_res", 32'(result), 32'sd0);
    rst_n = 1'b1;
    clr_ctl();
    run_full(16'sd8192, "t6_rerun", 16'sd7855);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
